// File: rtl/instr_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// instr_fetch_arbiter
//
// Round-robin arbiter that serialises per-warp instruction fetch requests onto
// a single instruction-memory read channel. One transaction is in flight at a
// time: IDLE picks a winner, REQ holds the memory request until the memory
// completes it, RESP returns the fetched word to the winner with a one-cycle
// ready pulse.
//
// Handshake semantics (both sides):
//   - A requester raises req_read_valid[i] with a stable req_read_address[i]
//     and holds both until it sees req_read_ready[i]. It drops valid in the
//     cycle after that pulse. The address is captured once at grant time;
//     later changes are not observed.
//   - The arbiter holds mem_read_valid and mem_read_address stable until the
//     memory answers with a one-cycle mem_read_ready pulse. mem_read_data is
//     valid in that same cycle. mem_read_ready outside REQ is ignored.
//
// Ports:
//   clk               clock, all state on rising edge
//   reset             asynchronous, active-high
//   req_read_valid    [N]        per-warp fetch request
//   req_read_address  [N][AW]    per-warp fetch address
//   req_read_ready    [N]        one-hot completion pulse (one cycle)
//   req_read_data     [N][DW]    fetched word, replicated on every port
//   mem_read_valid    request to instruction memory
//   mem_read_address  [AW]       address of the granted request
//   mem_read_ready    memory completion pulse
//   mem_read_data     [DW]       fetched word
//   busy              high whenever the FSM is not IDLE
//   fsm_state         [2]        current FSM state (IDLE=0, REQ=1, RESP=2)
//
// Every output is a register; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module instr_fetch_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_REQUESTERS-1:0]                  req_read_valid,
  input  logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0]  req_read_address,
  output logic [NUM_REQUESTERS-1:0]                  req_read_ready,
  output logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]  req_read_data,
  output logic                                       mem_read_valid,
  output logic [ADDR_WIDTH-1:0]                      mem_read_address,
  input  logic                                       mem_read_ready,
  input  logic [DATA_WIDTH-1:0]                      mem_read_data,
  output logic                                       busy,
  output logic [1:0]                                 fsm_state
);

  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQUESTERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state;
  logic [IDX_W-1:0]          grant;
  logic [IDX_W-1:0]          last_grant;

  logic                      pick_found;
  logic [IDX_W-1:0]          pick_idx;
  logic [IDX_W-1:0]          pick_cand;
  logic [NUM_REQUESTERS-1:0] grant_onehot;

  assign fsm_state = state;

  // Round-robin pick: scan from last_grant+1 upward, wrapping modulo the
  // requester count so non-power-of-2 counts never produce an invalid index.
  // The last candidate examined is last_grant itself, so a lone requester is
  // granted every time.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_cand  = '0;
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      pick_cand = IDX_W'((int'(last_grant) + i) % NUM_REQUESTERS);
      if (!pick_found && req_read_valid[pick_cand]) begin
        pick_found = 1'b1;
        pick_idx   = pick_cand;
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      grant_onehot[i] = (grant == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      grant            <= '0;
      last_grant       <= LAST_IDX;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      req_read_ready   <= '0;
      req_read_data    <= '0;
      busy             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_read_ready <= '0;
          if (pick_found) begin
            // The address is captured here and never re-sampled, so the
            // memory sees a stable address for the whole REQ phase.
            grant            <= pick_idx;
            mem_read_address <= req_read_address[pick_idx];
            mem_read_valid   <= 1'b1;
            busy             <= 1'b1;
            state            <= REQ;
          end
        end
        REQ: begin
          if (mem_read_ready) begin
            mem_read_valid <= 1'b0;
            last_grant     <= grant;
            req_read_data  <= {NUM_REQUESTERS{mem_read_data}};
            req_read_ready <= grant_onehot;
            state          <= RESP;
          end
        end
        RESP: begin
          // Pulse lasts exactly one cycle; the next pick happens in IDLE.
          req_read_ready <= '0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          mem_read_valid <= 1'b0;
          req_read_ready <= '0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_arbiter
//
// Bench for instr_fetch_arbiter. A 4-requester instance carries the main
// traffic; a 3-requester instance covers modulo wrap-around. The bench plays
// the memory: when it completes a memory request it pushes the expected
// {ready vector, data} pair, and a monitor pops it when a ready pulse appears.
// The expected winner comes from a small round-robin model kept by the bench.
// -----------------------------------------------------------------------------
module tb_instr_fetch_arbiter;

  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- DUT (4 requesters) ----------------
  logic [N-1:0]         valid;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0]         ready;
  logic [N-1:0][DW-1:0] rdata;
  logic                 mv;
  logic [AW-1:0]        ma;
  logic                 mr;
  logic [DW-1:0]        md;
  logic                 busy;
  logic [1:0]           st;

  instr_fetch_arbiter #(
    .NUM_REQUESTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_read_valid   (valid),
    .req_read_address (addr),
    .req_read_ready   (ready),
    .req_read_data    (rdata),
    .mem_read_valid   (mv),
    .mem_read_address (ma),
    .mem_read_ready   (mr),
    .mem_read_data    (md),
    .busy             (busy),
    .fsm_state        (st)
  );

  // ---------------- DUT (3 requesters) ----------------
  logic [N3-1:0]         v3;
  logic [N3-1:0][AW-1:0] a3;
  logic [N3-1:0]         r3;
  logic [N3-1:0][DW-1:0] d3;
  logic                  mv3;
  logic [AW-1:0]         ma3;
  logic                  mr3;
  logic [DW-1:0]         md3;
  logic                  busy3;
  logic [1:0]            st3;

  instr_fetch_arbiter #(
    .NUM_REQUESTERS(N3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut3 (
    .clk              (clk),
    .reset            (reset),
    .req_read_valid   (v3),
    .req_read_address (a3),
    .req_read_ready   (r3),
    .req_read_data    (d3),
    .mem_read_valid   (mv3),
    .mem_read_address (ma3),
    .mem_read_ready   (mr3),
    .mem_read_data    (md3),
    .busy             (busy3),
    .fsm_state        (st3)
  );

  // ---------------- checking ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [N+DW-1:0] exp_q[$];
  logic [N+DW-1:0] mon_e;
  logic [N-1:0]    prev_ready = '0;
  int              last_pulse_cyc = -1;
  bit              gap_chk = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_ready = '0;
    end else begin
      if (ready != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 64'(ready), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("ready_vec", 64'(ready), 64'(mon_e[N+DW-1:DW]));
          for (int p = 0; p < N; p++) check("ready_data", 64'(rdata[p]), 64'(mon_e[DW-1:0]));
        end
        check("ready_width", 64'(prev_ready), 64'(0));
        if (gap_chk && last_pulse_cyc >= 0) check("pulse_gap", 64'(cyc - last_pulse_cyc), 64'(3));
        last_pulse_cyc = cyc;
      end
      prev_ready = ready;
    end
  end

  // ---------------- round-robin model ----------------
  int m_last;

  function automatic int rr_next(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (last + i) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic rand_addrs();
    for (int i = 0; i < N; i++) addr[i] = ($urandom & 32'hFFFF_FF00) | 32'(i << 2);
  endtask

  // Play the memory for one transaction: wait for the request, check the
  // granted address, stall, then complete and push the expected response.
  task automatic serve(input int stall, input int idx, input logic [DW-1:0] data, input bit drop);
    int            n;
    logic [AW-1:0] a_exp;
    logic [N-1:0]  oh;
    n     = 0;
    a_exp = addr[idx];
    oh    = '0;
    oh[idx] = 1'b1;
    while (mv !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mem_valid_seen", 64'(mv), 64'(1));
    if (mv !== 1'b1) return;
    check("mem_addr", 64'(ma), 64'(a_exp));
    check("busy_req", 64'(busy), 64'(1));
    if (drop) begin
      valid[idx] = 1'b0;
      addr[idx]  = ~a_exp;
    end
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", 64'(mv), 64'(1));
      check("stall_addr", 64'(ma), 64'(a_exp));
      check("stall_busy", 64'(busy), 64'(1));
      @(negedge clk);
    end
    check("accept_addr", 64'(ma), 64'(a_exp));
    mr = 1'b1;
    md = data;
    exp_q.push_back({oh, data});
    m_last = idx;
    @(negedge clk);
    mr = 1'b0;
    md = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mv"}, 64'(mv), 64'(0));
    check({tag, "_ma"}, 64'(ma), 64'(0));
    check({tag, "_ready"}, 64'(ready), 64'(0));
    for (int p = 0; p < N; p++) check({tag, "_data"}, 64'(rdata[p]), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_state"}, 64'(st), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int w;
    int t0;
    logic [N-1:0]  v;
    logic [DW-1:0] x1;
    logic [DW-1:0] x2;

    reset = 1'b1;
    valid = '0;
    addr  = '0;
    mr    = 1'b0;
    md    = '0;
    v3    = '0;
    a3    = '0;
    mr3   = 1'b0;
    md3   = '0;
    rand_addrs();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset  = 1'b0;
    m_last = N - 1;
    @(negedge clk);

    // Reset in the middle of REQ with a memory response pending.
    valid = '1;
    n = 0;
    while (mv !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_req", 64'(mv), 64'(1));
    mr    = 1'b1;
    md    = 32'hBAD0_BAD0;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    mr    = 1'b0;
    check_reset_outputs("midrst_hold");
    reset = 1'b0;
    m_last = N - 1;

    // All four valid continuously: 0,1,2,3,0,1 with pulses 3 cycles apart.
    last_pulse_cyc = -1;
    gap_chk = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = rr_next(valid, m_last);
      serve(0, w, $urandom, 1'b0);
    end
    valid = '0;
    @(negedge clk);
    gap_chk = 1'b0;
    @(negedge clk);

    // Single fetch from requester 2, memory ready in the first REQ cycle.
    addr[2] = 32'h40;
    valid   = 4'b0100;
    t0      = cyc;
    serve(0, 2, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    valid = '0;
    check("latency", 64'(last_pulse_cyc - t0), 64'(2));
    @(negedge clk);

    // Memory stall of 5 cycles.
    valid = 4'b0010;
    w = rr_next(valid, m_last);
    serve(5, w, $urandom, 1'b0);
    valid = '0;
    @(negedge clk);
    check("idle_after_stall", 64'(busy), 64'(0));

    // Abandoned request: requester 1 drops valid (and scrambles its address)
    // during REQ; the transaction still completes with a pulse.
    valid = 4'b0010;
    w = rr_next(valid, m_last);
    serve(2, w, $urandom, 1'b1);
    @(negedge clk);
    check("abandon_idle_busy", 64'(busy), 64'(0));
    check("abandon_idle_state", 64'(st), 64'(0));
    repeat (2) @(negedge clk);
    check("abandon_no_rereq", 64'(mv), 64'(0));

    // Random request patterns and stalls.
    for (int k = 0; k < 10; k++) begin
      rand_addrs();
      v = N'($urandom_range(1, (1 << N) - 1));
      valid = v;
      w = rr_next(v, m_last);
      serve($urandom_range(0, 3), w, $urandom, 1'b0);
      valid = '0;
    end
    repeat (3) @(negedge clk);

    // Three requesters: last_grant starts at 2, so 0 wins before 2.
    for (int i = 0; i < N3; i++) a3[i] = ($urandom & 32'hFFFF_FF00) | 32'(i << 4);
    x1 = $urandom;
    x2 = $urandom;
    v3 = 3'b101;
    n = 0;
    while (mv3 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wrap_mv_first", 64'(mv3), 64'(1));
    check("wrap_addr_first", 64'(ma3), 64'(a3[0]));
    mr3 = 1'b1;
    md3 = x1;
    @(negedge clk);
    mr3 = 1'b0;
    check("wrap_ready_first", 64'(r3), 64'(3'b001));
    for (int p = 0; p < N3; p++) check("wrap_data_first", 64'(d3[p]), 64'(x1));
    v3[0] = 1'b0;
    n = 0;
    while (mv3 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wrap_mv_second", 64'(mv3), 64'(1));
    check("wrap_addr_second", 64'(ma3), 64'(a3[2]));
    mr3 = 1'b1;
    md3 = x2;
    @(negedge clk);
    mr3 = 1'b0;
    check("wrap_ready_second", 64'(r3), 64'(3'b100));
    for (int p = 0; p < N3; p++) check("wrap_data_second", 64'(d3[p]), 64'(x2));
    v3 = '0;
    repeat (3) @(negedge clk);
    check("wrap_idle", 64'(busy3), 64'(0));

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
